// File: rtl/alu_pkg.sv
// alu_pkg: op codes, flag bit positions, FSM encoding and default illegal-op result for alu_pipe.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOT  = 4'b0101,
    OP_SHL  = 4'b0110,
    OP_SHR  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLT  = 4'b1001,
    OP_SLTU = 4'b1010,
    OP_MUL  = 4'b1011
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  localparam logic [31:0] ILLEGAL_VAL_DEF = 32'hDEADBEEF;

  function automatic logic [3:0] pack_flags(input logic v, input logic c, input logic n, input logic z);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one partial product per cycle over WIDTH steps.
// done is high during the final step; product is valid in that same cycle.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step_s;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done       = (cnt_q == CNT_ONE);
  assign product    = acc_step_s;

  // Load on start, otherwise step while the counter is non-zero.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_INIT;
    end else if (cnt_q != '0) begin
      acc_d    = acc_step_s;
      mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q - CNT_ONE;
    end else begin
      cnt_d    = cnt_q;
    end
  end

  // Multiplier datapath and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with registered result, {V,C,N,Z} flags and error bit.
// Define ALU_MUL_EN to execute op 1011 on the iterative multiplier; otherwise 1011 is illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] ILLEGAL_VAL = ILLEGAL_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err
);
  localparam logic [WIDTH-1:0] ILLEGAL_W = WIDTH'(ILLEGAL_VAL);
  localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);

  logic             accept_s, mul_op_s, mul_done_s, b_big_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] diff_s, alu_res_s, mul_prod_s;
  logic             alu_c_s, alu_v_s, alu_err_s;
  logic [3:0]       alu_flags_s;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  assign accept_s = in_valid & in_ready;
  assign b_big_s  = (in_b >= WIDTH_V);
  assign sum_s    = {1'b0, in_a} + {1'b0, in_b};
  assign diff_s   = in_a - in_b;

`ifdef ALU_MUL_EN
  alu_state_e state_q, state_d;

  assign mul_op_s = (in_op == OP_MUL);
  assign in_ready = (state_q == ST_IDLE) & (~valid_q | out_ready);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_s & mul_op_s),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // IDLE/MUL sequencing; the multiplier's final step returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = (accept_s & mul_op_s) ? ST_MUL : ST_IDLE;
      ST_MUL:  state_d = mul_done_s ? ST_IDLE : ST_MUL;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign mul_op_s   = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_prod_s = '0;
  assign in_ready   = ~valid_q | out_ready;
`endif

  // Single-cycle op mux; carry and overflow are only produced by add and sub.
  always_comb begin
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (sum_s[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_c_s   = (in_a < in_b);
        alu_v_s   = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (diff_s[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res_s = in_a & in_b;
      OP_OR:   alu_res_s = in_a | in_b;
      OP_XOR:  alu_res_s = in_a ^ in_b;
      OP_NOT:  alu_res_s = ~in_a;
      OP_SHL:  alu_res_s = b_big_s ? '0 : (in_a << in_b);
      OP_SHR:  alu_res_s = b_big_s ? '0 : (in_a >> in_b);
      OP_SRA:  alu_res_s = b_big_s ? {WIDTH{in_a[WIDTH-1]}} : $unsigned($signed(in_a) >>> in_b);
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
`ifdef ALU_MUL_EN
      OP_MUL:  alu_res_s = '0;
`endif
      default: begin
        alu_res_s = ILLEGAL_W;
        alu_err_s = 1'b1;
      end
    endcase
  end

  assign alu_flags_s = alu_err_s ? 4'b0000 :
                       pack_flags(alu_v_s, alu_c_s, alu_res_s[WIDTH-1], (alu_res_s == '0));

  // Result register: consume clears valid, a new load (ALU or multiply) overrides it.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    if (valid_q & out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (mul_done_s) begin
      result_d = mul_prod_s;
      flags_d  = pack_flags(1'b0, 1'b0, mul_prod_s[WIDTH-1], (mul_prod_s == '0));
      err_d    = 1'b0;
      valid_d  = 1'b1;
    end else if (accept_s & ~mul_op_s) begin
      result_d = alu_res_s;
      flags_d  = alu_flags_s;
      err_d    = alu_err_s;
      valid_d  = 1'b1;
    end else begin
      result_d = result_q;
    end
  end

  // Output register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'b0000;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=32) plus a WIDTH=16 illegal-op check.
// Honours ALU_MUL_EN the same way the RTL does.
`timescale 1ns/1ps
module tb_alu_pipe;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0]  in_op, out_flags;
  logic        in_valid16, in_ready16, out_valid16, out_err16;
  logic [15:0] out_result16;
  logic [3:0]  out_flags16;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
    int          lat;
    bit          consec;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          last_pop_cyc = 0;
  bit          hold_v = 1'b0;
  logic [31:0] hold_res;
  logic [3:0]  hold_flags;
  logic        hold_err;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_err(out_err)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_op(in_op),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_result(out_result16), .out_flags(out_flags16), .out_err(out_err16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog act=time_expired req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [3:0] f, input logic e,
                              input int lat, input bit consec);
    exp_t x;
    x.res = r; x.flags = f; x.err = e; x.lat = lat; x.consec = consec; x.acc = 0;
    return x;
  endfunction

  // Reference model from the op definitions, using 64-bit integer arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t        x;
    longint      sa, sb, r;
    logic [63:0] w;
    logic        c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    x = mk(32'h0, 4'h0, 1'b0, 0, 1'b0);
    c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        w = {32'h0, a} + {32'h0, b}; x.res = w[31:0]; c = (w > 64'h0000_0000_FFFF_FFFF);
        r = sa + sb; v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd1: begin
        x.res = a - b; c = (a < b);
        r = sa - sb; v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd2: x.res = a & b;
      4'd3: x.res = a | b;
      4'd4: x.res = a ^ b;
      4'd5: x.res = ~a;
      4'd6: x.res = (b >= 32'd32) ? 32'h0 : (a << b);
      4'd7: x.res = (b >= 32'd32) ? 32'h0 : (a >> b);
      4'd8: begin
        if (b >= 32'd32) x.res = (sa < 0) ? 32'hFFFF_FFFF : 32'h0;
        else begin r = sa >>> b; x.res = r[31:0]; end
      end
      4'd9:  x.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: x.res = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd11: begin w = {32'h0, a} * {32'h0, b}; x.res = w[31:0]; end
`endif
      default: begin x.res = 32'hDEAD_BEEF; x.err = 1'b1; end
    endcase
    x.flags = x.err ? 4'h0 : {v, c, x.res[31], (x.res == 32'h0)};
    return x;
  endfunction

  // Present one operation; on acceptance stamp the accept edge and queue the expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input exp_t e, input bit push);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    #2;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout act=in_ready_low req=accept op=%h", op);
    end else begin
      e.acc = cyc + 1;
      if (push) exp_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout act=%0d_pending req=0", exp_q.size());
    end
  endtask

  // Monitor: drives out_ready per mode, pops/compares on each transfer, checks holding under backpressure.
  initial begin
    exp_t e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      #2;
      if (rst || !out_valid) begin
        hold_v = 1'b0;
      end else if (out_ready) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output act=%h req=none", out_result);
        end else begin
          e = exp_q.pop_front();
          chk("result", {32'h0, out_result}, {32'h0, e.res});
          chk("flags", {60'h0, out_flags}, {60'h0, e.flags});
          chk("err", {63'h0, out_err}, {63'h0, e.err});
          if (e.lat != 0) chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
          if (e.consec) chk("one_per_cycle", 64'(cyc - last_pop_cyc), 64'd1);
          last_pop_cyc = cyc;
        end
      end else begin
        chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
        if (hold_v) begin
          chk("held_result", {32'h0, out_result}, {32'h0, hold_res});
          chk("held_flags_err", {59'h0, out_flags, out_err}, {59'h0, hold_flags, hold_err});
        end
        hold_v = 1'b1; hold_res = out_result; hold_flags = out_flags; hold_err = out_err;
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    bit          seen;
    rst = 1'b1; in_valid = 1'b0; in_valid16 = 1'b0;
    in_a = 32'h0; in_b = 32'h0; in_op = 4'h0;
    #22 rst = 1'b0;
    #1;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_result", {32'h0, out_result}, 64'h0);
    chk("rst_out_flags_err", {59'h0, out_flags, out_err}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);

    rdy_mode = 0;
    issue(32'h7FFF_FFFF, 32'h1, 4'b0000, mk(32'h8000_0000, 4'b1010, 1'b0, 1, 1'b0), 1'b1);
    issue(32'h0, 32'h1, 4'b0001, mk(32'hFFFF_FFFF, 4'b0110, 1'b0, 1, 1'b0), 1'b1);
    issue(32'h8000_0000, 32'd31, 4'b0111, mk(32'h1, 4'b0000, 1'b0, 1, 1'b0), 1'b1);
    issue(32'h8000_0000, 32'd4, 4'b1000, mk(32'hF800_0000, 4'b0010, 1'b0, 1, 1'b0), 1'b1);
    issue(32'h8000_0000, 32'd32, 4'b0110, mk(32'h0, 4'b0001, 1'b0, 1, 1'b0), 1'b1);
    issue(32'h8000_0000, 32'd40, 4'b1000, mk(32'hFFFF_FFFF, 4'b0010, 1'b0, 1, 1'b0), 1'b1);
    issue(32'hFFFF_FFFF, 32'h1, 4'b1001, mk(32'h1, 4'b0000, 1'b0, 1, 1'b0), 1'b1);
    issue(32'hFFFF_FFFF, 32'h1, 4'b1010, mk(32'h0, 4'b0001, 1'b0, 1, 1'b0), 1'b1);
    issue(32'hFF00_FF00, 32'h0F0F_0F0F, 4'b0010, mk(32'h0F00_0F00, 4'b0000, 1'b0, 1, 1'b0), 1'b1);
    issue(32'hA5A5_A5A5, 32'hFFFF_FFFF, 4'b0100, mk(32'h5A5A_5A5A, 4'b0000, 1'b0, 1, 1'b0), 1'b1);
    issue(32'h0, 32'h0, 4'b0101, mk(32'hFFFF_FFFF, 4'b0010, 1'b0, 1, 1'b0), 1'b1);
    issue(32'h0, 32'h0, 4'b0011, mk(32'h0, 4'b0001, 1'b0, 1, 1'b0), 1'b1);
    issue(32'h1234, 32'h5678, 4'b1111, mk(32'hDEAD_BEEF, 4'b0000, 1'b1, 1, 1'b0), 1'b1);
    wait_drain();

`ifdef ALU_MUL_EN
    issue(32'd12345, 32'd6789, 4'b1011, mk(32'd83810205, 4'b0000, 1'b0, 33, 1'b0), 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      in_valid = (k < 20); in_a = $urandom; in_b = $urandom; in_op = 4'($urandom_range(0, 15));
      #2;
      if (in_ready) seen = 1'b1;
    end
    in_valid = 1'b0;
    chk("mul_in_ready_low", {63'h0, seen}, 64'h0);
`else
    issue(32'd12345, 32'd6789, 4'b1011, mk(32'hDEAD_BEEF, 4'b0000, 1'b1, 1, 1'b0), 1'b1);
`endif
    wait_drain();

    @(negedge clk);
    in_op = 4'b1111; in_valid16 = 1'b1;
    #2;
    chk("w16_in_ready", {63'h0, in_ready16}, 64'h1);
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    @(negedge clk);
    #2;
    chk("w16_valid", {63'h0, out_valid16}, 64'h1);
    chk("w16_result", {48'h0, out_result16}, 64'h0000_0000_0000_BEEF);
    chk("w16_flags_err", {59'h0, out_flags16, out_err16}, 64'h1);

    rdy_mode = 2;
    issue(32'd1, 32'd2, 4'b0000, mk(32'd3, 4'b0000, 1'b0, 0, 1'b0), 1'b1);
    fork
      begin
        issue(32'd10, 32'd3, 4'b0001, mk(32'd7, 4'b0000, 1'b0, 0, 1'b1), 1'b1);
        issue(32'hF0, 32'h0F, 4'b0100, mk(32'hFF, 4'b0000, 1'b0, 0, 1'b1), 1'b1);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          #3;
          chk("bp_hold_in_ready", {63'h0, in_ready}, 64'h0);
        end
        rdy_mode = 0;
      end
    join
    wait_drain();

`ifdef ALU_MUL_EN
    issue(32'd5, 32'd7, 4'b1011, mk(32'd35, 4'b0000, 1'b0, 0, 1'b0), 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("rst_mul_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_mul_in_ready", {63'h0, in_ready}, 64'h1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #2;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_mul_no_result", {63'h0, seen}, 64'h0);
`endif

    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 2))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(0, 40));
        default: b = 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000 - 32'($urandom_range(0, 1));
      issue(a, b, op, model(a, b, op), 1'b1);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
